case_code_issuer: RTL
=====================

Name: case_code_issuer

Overview:
- Transmit end of the 3-bit case-code interface. Collects sticky event requests for codes 0..7 and issues them one per handshake as a 3-bit code plus a 2-bit class tag over a valid/ready channel.
- Downstream is the case-dispatch decoder, which selects on 0, 1, 2, 3/4 and 5..7 ranges.
- Round-robin arbitration keeps any code from starving.
- Includes flush control, an overflow flag and an issued-code counter.

Parameters:
- CNT_WIDTH, 16, width of the issued-code counter; saturates.
- RR_EN, 1, 1 = round-robin selection; 0 = fixed priority, lowest code first.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_req  input  8  per-code request pulses; bit k requests code k.
- i_flush  input  1  discard all pending requests.
- o_valid  output  1  code/class valid.
- i_ready  input  1  downstream accepts when o_valid && i_ready.
- o_code  output  3  code being offered.
- o_class  output  2  class of o_code.
- o_pending  output  8  current pending request register.
- o_overflow  output  1  sticky; a request hit an already-pending code.
- o_count  output  CNT_WIDTH  number of accepted handshakes, saturating.

Behaviour:
- Reset (i_rst=1 at clock edge): state=IDLE, o_valid=0, o_code=0, o_class=0, o_pending=0, o_overflow=0, o_count=0, rr pointer=0. Reset mid-transfer drops o_valid immediately.
- Class map (must match the decoder's case arms): 0,1 -> 0 SINGLE; 2 -> 1 BLOCK; 3,4 -> 2 PAIR; 5,6,7 -> 3 RANGE. o_class is registered with o_code.
- Pending update each cycle: next = (pending & ~load_mask) | i_req.
  - load_mask is the one-hot of the code loaded this cycle.
  - A request for the code being loaded in the same cycle stays pending; this is not overflow.
- Overflow: set when i_req[k]=1 and pending[k]=1 and k is not being loaded this cycle. Sticky until reset.
- Output register loads when (!o_valid || i_ready) and at least one pending bit exists after masking.
  - Selection uses the registered pending value; requests arriving this cycle are eligible next cycle.
  - Latency: i_req pulse at edge t with output register empty -> o_valid=1 after edge t+1.
  - Back-to-back: with continuous i_ready=1 and pending codes available, one code is issued per cycle.
- Valid rule: once o_valid=1, o_code/o_class are stable and o_valid holds until a handshake. Flush does not drop o_valid.
- Round-robin (RR_EN=1):
  - Search starts at ptr and wraps 7->0.
  - After a load of code c, ptr = (c+1) mod 8; wrap from 7 gives 0.
- Fixed priority (RR_EN=0): lowest pending index wins.
- FSM:
  - IDLE: o_valid=0. Go to ACTIVE on a load. Flush here clears pending and stays in IDLE.
  - ACTIVE: o_valid=1. On handshake with nothing to load -> IDLE; with a load -> stay in ACTIVE. On i_flush -> FLUSHING, with pending cleared in that cycle.
  - FLUSHING: o_valid=1 holding the current code. i_req is ignored: not latched, no overflow. On handshake -> IDLE, no new load. A simultaneous flush and handshake in ACTIVE goes straight to IDLE.
- Counter: +1 per handshake; holds at 2^CNT_WIDTH-1.

Decomposition:
- Package case_code_pkg holds:
  - code_t (logic[3]) and class_t enum {SINGLE, BLOCK, PAIR, RANGE};
  - state_t enum {IDLE, ACTIVE, FLUSHING};
  - function code_class(code_t) -> class_t, implemented as case-inside with a ranged arm [5:7], shared with the decoder side;
  - constant N_CODES=8.
- Sub-module case_code_rr_pick: combinational; inputs pending[8], ptr[3], mask enable, RR_EN; outputs found and code_t.

Test Plan:
- Reset then i_req=8'b0000_0100 for one cycle, i_ready=1 -> o_valid=1 next cycle, o_code=2, o_class=BLOCK; o_count=1 after the handshake; o_pending=0.
- i_req=8'hFF for one cycle, i_ready=1 -> codes 0,1,...,7 on 8 consecutive cycles; classes 0,0,1,2,2,3,3,3; o_count=8; back to IDLE.
- Round-robin wrap: issue code 7 alone, then i_req=8'b1000_0001 -> code 0 is issued before 7. With RR_EN=0 the same stimulus also gives 0 first; a further i_req=8'h81 repeated after code 0 issues -> RR gives 7, fixed gives 0.
- Stall: o_valid=1 with o_code=3, i_ready=0 for 5 cycles while i_req=8'b0001_0000 -> o_code holds 3, o_pending=8'h10, no overflow. A second i_req[4] pulse -> o_overflow=1 and stays 1.
- Flush mid-transfer: pending=8'hF0, o_code=1 stalled, pulse i_flush -> o_pending=0 next cycle, o_valid stays 1 with code 1. i_req=8'h02 during FLUSHING is ignored. Raise i_ready -> handshake, then o_valid=0 and state IDLE.
- Synchronous reset asserted while o_valid=1 -> after the edge o_valid=0, o_count=0, o_overflow=0, o_pending=0.

Source files
------------

// File: rtl/case_code_pkg.sv
// Shared types for the 3-bit case-code link: code/class types, issuer FSM states,
// and the code-to-class map that must agree with the case-dispatch decoder's arms.
package case_code_pkg;

    localparam int N_CODES = 8;

    typedef logic [2:0] code_t;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        BLOCK  = 2'd1,
        PAIR   = 2'd2,
        RANGE  = 2'd3
    } class_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        FLUSHING = 2'd2
    } state_t;

    // Arms mirror the decoder: 0/1, 2, 3/4, 5..7.
    function automatic class_t code_class(input code_t code);
        class_t cls;
        case (code) inside
            3'd0, 3'd1:   cls = SINGLE;
            3'd2:         cls = BLOCK;
            3'd3, 3'd4:   cls = PAIR;
            [3'd5:3'd7]:  cls = RANGE;
            default:      cls = SINGLE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/case_code_rr_pick.sv
// Purpose: choose one pending code, round-robin from ptr or lowest-index-first.
// Latency: purely combinational.
// Backpressure: none; mask_en low forces found=0 so nothing is selected.
module case_code_rr_pick
    import case_code_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [N_CODES-1:0] pending,
    input  code_t              ptr,
    input  logic               mask_en,
    output logic               found,
    output code_t              code
);

    code_t start;
    code_t idx;

    // Walk offsets from the far end so the smallest offset from start wins.
    always_comb begin
        found = 1'b0;
        code  = '0;
        idx   = '0;
        start = RR_EN ? ptr : code_t'(0);
        for (int i = N_CODES - 1; i >= 0; i--) begin
            idx = start + code_t'(i);
            if (mask_en && pending[idx]) begin
                found = 1'b1;
                code  = idx;
            end
        end
    end

endmodule

// File: rtl/case_code_issuer.sv
// Purpose: collect sticky code requests and issue one code+class per valid/ready handshake.
// Latency: request pulse at edge t reaches o_valid after edge t+1 when the output slot is free.
// Backpressure: o_code/o_class hold while o_valid && !i_ready; requests keep accumulating.
module case_code_issuer
    import case_code_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter bit RR_EN     = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_CODES-1:0]   i_req,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2:0]           o_code,
    output logic [1:0]           o_class,
    output logic [N_CODES-1:0]   o_pending,
    output logic                 o_overflow,
    output logic [CNT_WIDTH-1:0] o_count
);

    state_t               state;
    state_t               state_nxt;
    logic [N_CODES-1:0]   pending;
    logic [N_CODES-1:0]   pending_nxt;
    logic [N_CODES-1:0]   load_mask;
    code_t                ptr;
    code_t                pick;
    logic                 found;
    logic                 hs;
    logic                 can_load;
    logic                 load;
    logic                 ovf_set;
    logic                 valid_q;
    code_t                code_q;
    class_t               cls_q;
    logic                 ovf_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    assign hs = valid_q && i_ready;

    // A flush or a draining FLUSHING slot blocks any new load.
    assign can_load = (!valid_q || i_ready) && !i_flush && (state != FLUSHING);

    case_code_rr_pick #(
        .RR_EN   (RR_EN)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .mask_en (can_load),
        .found   (found),
        .code    (pick)
    );

    assign load      = found;
    assign load_mask = load ? (N_CODES'(1) << pick) : '0;
    assign ovf_set   = (state != FLUSHING) && (|(i_req & pending & ~load_mask));

    always_comb begin
        pending_nxt = pending;
        if (i_flush) begin
            pending_nxt = '0;
        end else if (state != FLUSHING) begin
            pending_nxt = (pending & ~load_mask) | i_req;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (i_flush)          state_nxt = hs ? IDLE : FLUSHING;
                else if (hs && !load) state_nxt = IDLE;
            end
            FLUSHING: begin
                if (hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            pending <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            cls_q   <= SINGLE;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (load) begin
                valid_q <= 1'b1;
                code_q  <= pick;
                cls_q   <= code_class(pick);
                ptr     <= pick + code_t'(1);
            end else if (hs) begin
                valid_q <= 1'b0;
            end
            if (ovf_set) ovf_q <= 1'b1;
            if (hs && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign o_valid    = valid_q;
    assign o_code     = code_q;
    assign o_class    = cls_q;
    assign o_pending  = pending;
    assign o_overflow = ovf_q;
    assign o_count    = cnt_q;

endmodule
